// File: rtl/ysyx_23060201_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// State encoding is fixed so that waveforms and debug tools agree.
package ysyx_23060201_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int          IFU_XLEN     = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060201_ifu.sv
// Single-outstanding, non-speculative instruction fetch unit.
// Owns the PC, fetches one word at a time and holds it for decode.
module ysyx_23060201_ifu
  import ysyx_23060201_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          XLEN     = IFU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  ifu_state_t      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            kill, kill_nxt;
  logic            latch;
  logic            req_fire;
  logic            inst_fire;

  assign req_fire  = mem_req_valid && mem_req_ready;
  assign inst_fire = inst_valid && inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      kill  <= kill_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst     <= '0;
      inst_pc  <= '0;
      inst_err <= 1'b0;
    end else if (latch) begin
      inst     <= mem_resp_data;
      inst_pc  <= pc;
      inst_err <= mem_resp_err;
    end
  end

  // A redirect overrides every other event of the same cycle.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    kill_nxt  = kill;
    latch     = 1'b0;
    if (redirect_valid) begin
      pc_nxt = align_pc(redirect_pc);
      unique case (state)
        S_IDLE: state_nxt = S_REQ;
        S_REQ: begin
          if (req_fire) begin
            state_nxt = S_WAIT;
            kill_nxt  = 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state_nxt = S_REQ;
            kill_nxt  = 1'b0;
          end else begin
            kill_nxt  = 1'b1;
          end
        end
        S_HOLD: state_nxt = S_REQ;
        default: state_nxt = S_IDLE;
      endcase
    end else begin
      unique case (state)
        S_IDLE: state_nxt = S_REQ;
        S_REQ: begin
          if (req_fire) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            kill_nxt  = 1'b0;
            latch     = !kill;
            state_nxt = kill ? S_REQ : S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_fire) begin
            pc_nxt    = pc + XLEN'(4);
            state_nxt = S_REQ;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_valid = (state == S_REQ);
    inst_valid    = (state == S_HOLD);
  end

  assign mem_req_addr = pc;

  // Responses are only legal while a fetch is outstanding.
  resp_in_wait: assert property (
    @(posedge clk) disable iff (rst)
    mem_resp_valid |-> (state == S_WAIT)
  );

endmodule

// File: tb/tb_ysyx_23060201_ifu.sv
// Bench for the fetch unit: directed scenarios then random traffic,
// checked against an instruction-stream reference model.
module tb_ysyx_23060201_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_23060201_ifu #(
    .RESET_PC(RPC),
    .XLEN(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_err(inst_err),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs  = 0;

  // reference model: next instruction address to be delivered
  logic [31:0] m_pc;
  // memory model
  bit          pend;
  int          cnt;
  int          g_dly;
  logic [31:0] p_addr;
  // stability trackers
  bit          req_chk;
  logic [31:0] h_addr;
  bit          hold_chk;
  logic [31:0] h_inst;
  logic [31:0] h_pc;
  logic        h_err;
  int          n_steps;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RPC) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[5:2] == 4'h2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: called just after a falling edge, returns after the next.
  task automatic cycle(input bit rdy, input bit irdy, input bit rv,
                       input logic [31:0] rpc);
    bit resp_now;
    bit fire_req;
    bit fire_inst;
    if (req_chk) begin
      chk("req_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("req_hold_addr", mem_req_addr, h_addr);
    end
    if (hold_chk) begin
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_inst", inst, h_inst);
      chk("hold_pc", inst_pc, h_pc);
      chk("hold_err", 32'(inst_err), 32'(h_err));
    end
    mem_req_ready  = rdy;
    inst_ready     = irdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    resp_now = pend && (cnt == 0);
    if (resp_now) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(p_addr);
      mem_resp_err   = mem_err(p_addr);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      mem_resp_err   = 1'($urandom_range(0, 1));
    end
    fire_req  = mem_req_valid && rdy;
    fire_inst = inst_valid && irdy && !rv;
    if (fire_req) chk("req_addr", mem_req_addr, m_pc);
    if (fire_inst) begin
      chk("inst_pc", inst_pc, m_pc);
      chk("inst", inst, mem_word(m_pc));
      chk("inst_err", 32'(inst_err), 32'(mem_err(m_pc)));
      n_hs++;
      m_pc = m_pc + 32'd4;
    end
    if (rv) m_pc = {rpc[31:2], 2'b00};
    if (resp_now) pend = 1'b0;
    else if (pend) cnt--;
    if (fire_req) begin
      pend   = 1'b1;
      cnt    = g_dly;
      p_addr = mem_req_addr;
    end
    req_chk  = mem_req_valid && !rdy && !rv;
    h_addr   = mem_req_addr;
    hold_chk = inst_valid && !irdy && !rv;
    h_inst   = inst;
    h_pc     = inst_pc;
    h_err    = inst_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to_hold(input int max, input bit rdy);
    n_steps = 0;
    while (!inst_valid && n_steps < max) begin
      cycle(rdy, 1'b0, 1'b0, 32'd0);
      n_steps++;
    end
    chk("hold_reached", 32'(inst_valid), 32'd1);
  endtask

  task automatic run_to_req(input int max);
    n_steps = 0;
    while (!mem_req_valid && n_steps < max) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      n_steps++;
    end
    chk("req_reached", 32'(mem_req_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0;
    int lat;
    bit r_rv;
    bit r_rdy;
    bit r_irdy;
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    pend = 1'b0; cnt = 0; g_dly = 0; p_addr = '0;
    req_chk = 1'b0; hold_chk = 1'b0;
    h_addr = '0; h_inst = '0; h_pc = '0; h_err = 1'b0;
    m_pc = RPC;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", mem_req_addr, RPC);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", 32'(inst_err), 32'd0);
    rst = 1'b0;

    // first fetch, zero-wait memory
    g_dly = 0;
    run_to_req(4);
    lat = n_steps;
    chk("first_addr", mem_req_addr, RPC);
    run_to_hold(8, 1'b1);
    chk("first_latency", 32'(lat + n_steps), 32'd3);
    chk("first_inst", inst, 32'h0000_0413);
    chk("first_pc", inst_pc, RPC);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      chk("stall_no_req", 32'(mem_req_valid), 32'd0);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("after_hs_req", 32'(mem_req_valid), 32'd1);
    chk("after_hs_addr", mem_req_addr, 32'h8000_0004);
    chk("hs_count", 32'(n_hs), 32'd1);

    // redirect while waiting, response arrives later and is dropped
    g_dly = 2;
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h8000_0103);
    for (int i = 0; i < 6 && pend; i++) begin
      chk("kill_no_valid", 32'(inst_valid), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
    end
    chk("kill_no_valid2", 32'(inst_valid), 32'd0);
    chk("kill_req", 32'(mem_req_valid), 32'd1);
    chk("kill_addr", mem_req_addr, 32'h8000_0100);

    // redirect in HOLD beats a same-cycle handshake
    g_dly = 0;
    run_to_hold(6, 1'b1);
    chk("hold_pc_100", inst_pc, 32'h8000_0100);
    hs0 = n_hs;
    cycle(1'b1, 1'b1, 1'b1, 32'h8000_0200);
    chk("redir_no_hs", 32'(n_hs), 32'(hs0));
    chk("redir_drop", 32'(inst_valid), 32'd0);
    chk("redir_addr", mem_req_addr, 32'h8000_0200);

    // faulting fetch
    cycle(1'b0, 1'b0, 1'b1, 32'h8000_0008);
    run_to_hold(6, 1'b1);
    chk("err_flag", 32'(inst_err), 32'd1);
    chk("err_pc", inst_pc, 32'h8000_0008);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("err_next", mem_req_addr, 32'h8000_000C);

    // PC wrap
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run_to_hold(6, 1'b1);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wrap_addr", mem_req_addr, 32'h0000_0000);

    // asynchronous reset while waiting
    g_dly = 3;
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("arst_inst_valid", 32'(inst_valid), 32'd0);
    chk("arst_addr", mem_req_addr, RPC);
    pend = 1'b0; req_chk = 1'b0; hold_chk = 1'b0;
    m_pc = RPC;
    @(negedge clk);
    rst = 1'b0;
    run_to_req(4);
    chk("arst_restart", mem_req_addr, RPC);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      r_rv   = ($urandom_range(0, 9) == 0);
      r_rdy  = 1'($urandom_range(0, 1));
      r_irdy = 1'($urandom_range(0, 1));
      g_dly  = $urandom_range(0, 3);
      cycle(r_rdy, r_irdy, r_rv, r_rv ? $urandom : 32'd0);
    end
    chk("progress", 32'(n_hs > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
